// File: rtl/sdram_exerciser_pkg.sv
// sdram_exerciser_pkg: state encoding, Galois LFSR taps and defaults shared by the SDRAM exerciser.
package sdram_exerciser_pkg;
  typedef enum logic [2:0] {IDLE, WR_REQ, RD_REQ, NEXT, DONE} state_t;
  localparam int DEF_TIMEOUT = 1023;
  localparam int DEF_ERR_W = 16;
  localparam logic [7:0] LFSR_TAPS_8 = 8'hB8;
  localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
  localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;
  function automatic logic [31:0] lfsr_taps(input int w);
    return w == 8 ? 32'(LFSR_TAPS_8) : w == 16 ? 32'(LFSR_TAPS_16) : LFSR_TAPS_32;
  endfunction
endpackage

// File: rtl/exerciser_pattern_gen.sv
// exerciser_pattern_gen: data for word i of pass p; counter pattern inverted on odd passes,
// or a Galois LFSR replayed for the read phase when EXERCISER_LFSR_EN is defined.
module exerciser_pattern_gen
  import sdram_exerciser_pkg::*;
#(
  parameter int DATA_W = 16
) (
`ifdef EXERCISER_LFSR_EN
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              load_i,
  input  logic              load_odd_i,
  input  logic              step_i,
`else
  input  logic [DATA_W-1:0] idx_i,
  input  logic              odd_i,
`endif
  output logic [DATA_W-1:0] pat_o
);
`ifdef EXERCISER_LFSR_EN
  localparam logic [DATA_W-1:0] TAPS = DATA_W'(lfsr_taps(DATA_W));
  logic [DATA_W-1:0] lfsr;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) lfsr <= '0;
    else if (load_i) lfsr <= DATA_W'(1) ^ {DATA_W{load_odd_i}};
    else if (step_i) lfsr <= (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
  assign pat_o = lfsr;
`else
  assign pat_o = idx_i ^ {DATA_W{odd_i}};
`endif
endmodule

// File: rtl/sdram_rw_exerciser.sv
// sdram_rw_exerciser: writes a pattern over an address window, reads it back and checks it.
// Optional LFSR pattern via EXERCISER_LFSR_EN.
module sdram_rw_exerciser
  import sdram_exerciser_pkg::*;
#(
  parameter int ADDR_W     = 24,
  parameter int DATA_W     = 16,
  parameter int START_ADDR = 0,
  parameter int ADDR_STEP  = 1,
  parameter int NUM_WORDS  = 256,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int ERR_W      = DEF_ERR_W
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              loop_i,
  input  logic              abort_i,
  output logic              host_wr_o,
  output logic              host_rd_o,
  output logic [ADDR_W-1:0] host_addr_o,
  output logic [DATA_W-1:0] host_data_o,
  input  logic [DATA_W-1:0] host_data_i,
  input  logic              host_done_i,
  input  logic              host_rdPending_i,
  output logic              busy_o,
  output logic              finished_o,
  output logic              pass_o,
  output logic              timeout_o,
  output logic [ERR_W-1:0]  err_cnt_o,
  output logic [ADDR_W-1:0] first_err_addr_o,
  output logic [15:0]       pass_cnt_o
);
  localparam int TW = TIMEOUT < 1 ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_WORDS - 1);
  localparam logic [ADDR_W-1:0] A0 = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;
  state_t state;
  logic start_q, pass_odd;
  logic [ADDR_W-1:0] idx, cur_addr;
  logic [TW-1:0] wait_cnt;
  logic [DATA_W-1:0] pat;
  logic unused_rd_pending;
  assign unused_rd_pending = host_rdPending_i;
  wire start_rise = start_i & ~start_q;
  wire req = host_wr_o | host_rd_o;
  wire last = idx == LAST;
`ifdef EXERCISER_LFSR_EN
  wire lfsr_load = ((state == IDLE || state == DONE) && start_rise) ||
                   (state == WR_REQ && host_wr_o && host_done_i && last) ||
                   (state == NEXT && loop_i && !abort_i);
  wire lfsr_odd = state == NEXT ? ~pass_odd : state == WR_REQ ? pass_odd : 1'b0;
  exerciser_pattern_gen #(.DATA_W(DATA_W)) u_pat (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .load_i(lfsr_load), .load_odd_i(lfsr_odd),
    .step_i(req & host_done_i), .pat_o(pat)
  );
`else
  exerciser_pattern_gen #(.DATA_W(DATA_W)) u_pat (
    .idx_i(DATA_W'(idx)), .odd_i(pass_odd), .pat_o(pat)
  );
`endif
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state <= IDLE;
      start_q <= 1'b0;
      pass_odd <= 1'b0;
      idx <= '0;
      cur_addr <= '0;
      wait_cnt <= '0;
      host_wr_o <= 1'b0;
      host_rd_o <= 1'b0;
      host_addr_o <= '0;
      host_data_o <= '0;
      busy_o <= 1'b0;
      finished_o <= 1'b0;
      pass_o <= 1'b0;
      timeout_o <= 1'b0;
      err_cnt_o <= '0;
      first_err_addr_o <= '0;
      pass_cnt_o <= '0;
    end else begin
      start_q <= start_i;
      case (state)
        IDLE, DONE: begin
          if (state == DONE) begin
            finished_o <= 1'b1;
            busy_o <= 1'b0;
            pass_o <= err_cnt_o == '0 && !timeout_o;
          end
          if (start_rise) begin
            state <= WR_REQ;
            busy_o <= 1'b1;
            finished_o <= 1'b0;
            pass_o <= 1'b0;
            timeout_o <= 1'b0;
            err_cnt_o <= '0;
            first_err_addr_o <= '0;
            pass_cnt_o <= '0;
            idx <= '0;
            cur_addr <= A0;
            pass_odd <= 1'b0;
          end
        end
        WR_REQ, RD_REQ: begin
          // a low request cycle is the mandatory gap before the next request
          if (!req) begin
            host_wr_o <= state == WR_REQ;
            host_rd_o <= state == RD_REQ;
            host_addr_o <= cur_addr;
            if (state == WR_REQ) host_data_o <= pat;
            wait_cnt <= '0;
          end else if (host_done_i) begin
            host_wr_o <= 1'b0;
            host_rd_o <= 1'b0;
            if (host_rd_o && host_data_i != pat) begin
              if (err_cnt_o != ERR_MAX) err_cnt_o <= err_cnt_o + 1'b1;
              if (err_cnt_o == '0) first_err_addr_o <= host_addr_o;
            end
            idx <= last ? '0 : idx + 1'b1;
            cur_addr <= last ? A0 : cur_addr + STEP;
            state <= abort_i ? DONE : !last ? state : host_wr_o ? RD_REQ : NEXT;
          end else if (wait_cnt == TMAX) begin
            host_wr_o <= 1'b0;
            host_rd_o <= 1'b0;
            timeout_o <= 1'b1;
            state <= DONE;
          end else wait_cnt <= wait_cnt + 1'b1;
        end
        NEXT: begin
          pass_cnt_o <= pass_cnt_o + 1'b1;
          if (loop_i && !abort_i) pass_odd <= ~pass_odd;
          state <= loop_i && !abort_i ? WR_REQ : DONE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
